adma2_engine: RTL and testbench
===============================

ADMA2_ENGINE -- requirements
Module: adma2_engine

Interface
REQ-001 Parameter ADDR_W, default 32, system address width (32 or 64).
REQ-002 Parameter DESC_W, default ADDR_W+32, descriptor width in bits.
REQ-003 Parameter DESC_BYTES, default DESC_W/8, descriptor pointer increment in bytes.
REQ-004 The block SHALL use one clock, CLK; reset RESET is asynchronous and active-high.
REQ-005 CLK  in  1  system clock.
REQ-006 RESET  in  1  asynchronous active-high reset.
REQ-007 start  in  1  command-register write; begins a chain at desc_base.
REQ-008 resume  in  1  continue the chain from the current descriptor pointer.
REQ-009 stop_req  in  1  stop-at-block-gap request.
REQ-010 desc_base  in  ADDR_W  ADMA system address register.
REQ-011 desc_rd_req / desc_rd_addr  out  1 / ADDR_W  descriptor fetch request and address.
REQ-012 desc_rd_ack / desc_rd_err / desc_rd_data  in  1 / 1 / DESC_W  fetch completion, bus error, data.
REQ-013 xfer_start / xfer_addr / xfer_len  out  1 / ADDR_W / 17  data-transfer launch pulse, address, byte count.
REQ-014 xfer_done  in  1  data transfer of the current descriptor is complete.
REQ-015 int_pulse / adma_err / err_state / busy / state  out  1 / 1 / 2 / 1 / 2  status.

Function
REQ-016 Descriptor fields: address [DESC_W-1:32], length [31:16], ACT2 [5], ACT1 [4], INT [2], END [1], VALID [0]; ACT2:ACT1 = 00 NOP, 01 RSV, 10 TRAN, 11 LINK.
REQ-017 States: ST_STOP=0, ST_FDS=1, ST_CADR=2, ST_TFR=3; state output = current state; busy = (state != ST_STOP).
REQ-018 ST_STOP: start -> load desc_ptr from desc_base, go ST_FDS; else resume -> ST_FDS with desc_ptr unchanged; start has priority over resume; start/resume ignored outside ST_STOP.
REQ-019 ST_FDS: desc_rd_req held high with desc_rd_addr = desc_ptr until the cycle of desc_rd_ack; data latched on that edge.
REQ-020 On ack with desc_rd_err=1 or VALID=0: adma_err pulses one cycle, err_state = 1 (FDS), go ST_STOP, desc_ptr unchanged.
REQ-021 On ack with valid descriptor: go ST_CADR (exactly one cycle there).
REQ-022 ST_CADR: desc_ptr <= address field if LINK, else desc_ptr + DESC_BYTES (modulo 2^ADDR_W).
REQ-023 ST_CADR with TRAN: xfer_start pulses one cycle, xfer_addr = address field, xfer_len = length, length 0 encoded as 65536; go ST_TFR.
REQ-024 ST_CADR non-TRAN: go ST_STOP if END or stop pending, else ST_FDS.
REQ-025 ST_TFR: hold until xfer_done; then ST_STOP if END or stop pending, else ST_FDS.
REQ-026 stop_req is latched into stop-pending in any non-STOP state, cleared on entry to ST_STOP; ignored in ST_STOP.
REQ-027 int_pulse is one cycle, asserted on the descriptor completion edge (leaving ST_CADR for non-TRAN, leaving ST_TFR for TRAN) when INT=1.
REQ-028 xfer_done outside ST_TFR and desc_rd_ack outside ST_FDS are ignored.
REQ-029 err_state holds its value until the next start; err_state = 0 means no error; adma_err never asserts without err_state update.

Reset
REQ-030 RESET asserted at any time forces state ST_STOP, desc_ptr 0, stop-pending 0, all outputs 0, in-flight fetch/transfer abandoned.
REQ-031 First state change after RESET deasserts occurs no earlier than the first rising CLK edge.

Structure
REQ-032 Package adma_pkg SHALL hold state encodings, ACT codes, descriptor bit positions and err_state codes.
REQ-033 Sub-module adma_desc_decode SHALL split DESC_W data into fields and NOP/RSV/TRAN/LINK flags, purely combinational.

Verification
REQ-034 start, desc_base=0x1000, one TRAN descriptor len=0x0200 END=1 INT=1 -> desc_rd_addr=0x1000, xfer_start with addr/len 0x200, int_pulse after xfer_done, state returns 0.
REQ-035 Chain NOP -> LINK(0x4000) -> TRAN END at 0x4000 -> fetch addresses 0x1000, 0x1008, 0x4000; single xfer_start.
REQ-036 Descriptor VALID=0 at 0x2000 -> adma_err pulse, err_state=1, STOP; resume re-fetches 0x2000.
REQ-037 stop_req during ST_TFR of non-END descriptor -> STOP after xfer_done, no further fetch; resume fetches next descriptor.
REQ-038 TRAN len=0 with ADDR_W=64 -> xfer_len=65536, desc_ptr increments by 12.
REQ-039 RESET asserted mid ST_TFR -> state 0, busy 0, all outputs 0 within same cycle (async).

Source files
------------

// File: rtl/adma_pkg.sv
// Shared encodings for the ADMA2 descriptor engine: FSM states, descriptor
// layout, action codes and error-state codes.
package adma_pkg;
    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_FDS  = 2'd1,
        ST_CADR = 2'd2,
        ST_TFR  = 2'd3
    } adma_state_e;

    typedef enum logic [1:0] {
        ACT_NOP  = 2'b00,
        ACT_RSV  = 2'b01,
        ACT_TRAN = 2'b10,
        ACT_LINK = 2'b11
    } adma_act_e;

    localparam int D_VALID   = 0;
    localparam int D_END     = 1;
    localparam int D_INT     = 2;
    localparam int D_ACT1    = 4;
    localparam int D_ACT2    = 5;
    localparam int D_LEN_LO  = 16;
    localparam int D_LEN_HI  = 31;
    localparam int D_ADDR_LO = 32;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_FDS  = 2'd1;
    localparam logic [1:0] ERR_CADR = 2'd2;
    localparam logic [1:0] ERR_TFR  = 2'd3;

    // A zero length field means a full 64 KiB transfer.
    function automatic logic [16:0] len_enc(input logic [15:0] len);
        return (len == 16'd0) ? 17'h10000 : {1'b0, len};
    endfunction
endpackage

// File: rtl/adma2_engine_if.sv
// Descriptor-fetch and data-transfer handshake bundle between the ADMA2
// engine (master) and the system bus / data path (slave).
interface adma2_engine_if #(
    parameter int ADDR_W = 32,
    parameter int DESC_W = ADDR_W + 32
);
    logic              desc_rd_req;
    logic [ADDR_W-1:0] desc_rd_addr;
    logic              desc_rd_ack;
    logic              desc_rd_err;
    logic [DESC_W-1:0] desc_rd_data;
    logic              xfer_start;
    logic [ADDR_W-1:0] xfer_addr;
    logic [16:0]       xfer_len;
    logic              xfer_done;

    modport master (
        output desc_rd_req, desc_rd_addr, xfer_start, xfer_addr, xfer_len,
        input  desc_rd_ack, desc_rd_err, desc_rd_data, xfer_done
    );
    modport slave (
        input  desc_rd_req, desc_rd_addr, xfer_start, xfer_addr, xfer_len,
        output desc_rd_ack, desc_rd_err, desc_rd_data, xfer_done
    );
endinterface

// File: rtl/adma_desc_decode.sv
// Combinational split of a raw ADMA2 descriptor into fields and action flags.
module adma_desc_decode
    import adma_pkg::*;
#(
    parameter int DESC_W = 64
) (
    input  logic [DESC_W-1:0]  desc,
    output logic [DESC_W-33:0] addr,
    output logic [15:0]        len,
    output logic               valid,
    output logic               end_f,
    output logic               int_f,
    output logic               is_nop,
    output logic               is_rsv,
    output logic               is_tran,
    output logic               is_link
);
    adma_act_e act;
    logic      unused;

    assign act     = adma_act_e'({desc[D_ACT2], desc[D_ACT1]});
    assign addr    = desc[DESC_W-1:D_ADDR_LO];
    assign len     = desc[D_LEN_HI:D_LEN_LO];
    assign valid   = desc[D_VALID];
    assign end_f   = desc[D_END];
    assign int_f   = desc[D_INT];
    assign is_nop  = (act == ACT_NOP);
    assign is_rsv  = (act == ACT_RSV);
    assign is_tran = (act == ACT_TRAN);
    assign is_link = (act == ACT_LINK);
    assign unused  = ^{desc[D_LEN_LO-1:D_ACT2+1], desc[D_INT+1]};
endmodule

// File: rtl/adma2_engine.sv
// ADMA2 descriptor engine: fetches descriptors, follows LINKs, launches TRAN
// transfers and reports completion interrupts and fetch errors.
module adma2_engine
    import adma_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DESC_W     = ADDR_W + 32,
    parameter int DESC_BYTES = DESC_W / 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              resume,
    input  logic              stop_req,
    input  logic [ADDR_W-1:0] desc_base,
    adma2_engine_if.master    bus,
    output logic              int_pulse,
    output logic              adma_err,
    output logic [1:0]        err_state,
    output logic              busy,
    output logic [1:0]        state
);
    adma_state_e       cur, nxt;
    logic [ADDR_W-1:0] desc_ptr;
    logic [DESC_W-1:0] desc_q;
    logic              stop_pend;
    logic              fetch_bad, cpl, xfer_act, unused;

    logic [DESC_W-33:0] d_addr;
    logic [15:0]        d_len;
    logic d_valid, d_end, d_int, d_nop, d_rsv, d_tran, d_link;

    adma_desc_decode #(.DESC_W(DESC_W)) u_dec (
        .desc(desc_q), .addr(d_addr), .len(d_len), .valid(d_valid),
        .end_f(d_end), .int_f(d_int), .is_nop(d_nop), .is_rsv(d_rsv),
        .is_tran(d_tran), .is_link(d_link)
    );

    // desc_q only ever holds fetched-valid descriptors, so these are redundant here.
    assign unused    = ^{d_valid, d_nop, d_rsv};
    assign fetch_bad = bus.desc_rd_err | ~bus.desc_rd_data[D_VALID];

    always_comb begin
        nxt = cur;
        cpl = 1'b0;
        case (cur)
            ST_STOP: if (start || resume) nxt = ST_FDS;
            ST_FDS:  if (bus.desc_rd_ack) nxt = fetch_bad ? ST_STOP : ST_CADR;
            ST_CADR: begin
                if (d_tran) nxt = ST_TFR;
                else begin
                    cpl = 1'b1;
                    nxt = (d_end || stop_pend) ? ST_STOP : ST_FDS;
                end
            end
            ST_TFR: if (bus.xfer_done) begin
                cpl = 1'b1;
                nxt = (d_end || stop_pend) ? ST_STOP : ST_FDS;
            end
            default: nxt = ST_STOP;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cur       <= ST_STOP;
            desc_ptr  <= '0;
            desc_q    <= '0;
            stop_pend <= 1'b0;
            err_state <= ERR_NONE;
            adma_err  <= 1'b0;
            int_pulse <= 1'b0;
        end else begin
            cur       <= nxt;
            adma_err  <= 1'b0;
            int_pulse <= cpl & d_int;
            stop_pend <= (nxt == ST_STOP) ? 1'b0
                       : (stop_pend | ((cur != ST_STOP) & stop_req));
            case (cur)
                ST_STOP: if (start) begin
                    desc_ptr  <= desc_base;
                    err_state <= ERR_NONE;
                end
                ST_FDS: if (bus.desc_rd_ack) begin
                    if (fetch_bad) begin
                        adma_err  <= 1'b1;
                        err_state <= ERR_FDS;
                    end else begin
                        desc_q <= bus.desc_rd_data;
                    end
                end
                ST_CADR: desc_ptr <= d_link ? ADDR_W'(d_addr)
                                            : desc_ptr + ADDR_W'(DESC_BYTES);
                default: ;
            endcase
        end
    end

    // Transfer address/length are presented for the whole TRAN and zero otherwise.
    assign xfer_act         = d_tran & ((cur == ST_CADR) | (cur == ST_TFR));
    assign bus.desc_rd_req  = (cur == ST_FDS);
    assign bus.desc_rd_addr = (cur == ST_FDS) ? desc_ptr : '0;
    assign bus.xfer_start   = (cur == ST_CADR) & d_tran;
    assign bus.xfer_addr    = xfer_act ? ADDR_W'(d_addr) : '0;
    assign bus.xfer_len     = xfer_act ? len_enc(d_len) : 17'd0;
    assign busy             = (cur != ST_STOP);
    assign state            = cur;
endmodule

// File: tb/tb_adma2_engine.sv
// Scoreboard bench for adma2_engine (64-bit addressing): a chain-walking
// reference model predicts fetch/transfer/interrupt/error/stop events.
module tb_adma2_engine;
    localparam int AW = 64;
    localparam int DW = AW + 32;
    localparam logic [63:0] DB = 64'd12;

    typedef enum {EV_FETCH, EV_XFER, EV_INT, EV_ERR, EV_STOP} ev_e;
    typedef struct {ev_e kind; logic [63:0] a; logic [16:0] b;} ev_t;

    logic CLK = 1'b0;
    logic RESET, start, resume, stop_req;
    logic [AW-1:0] desc_base;
    logic int_pulse, adma_err, busy;
    logic [1:0] err_state, state_o;

    adma2_engine_if #(.ADDR_W(AW), .DESC_W(DW)) bus ();

    adma2_engine #(.ADDR_W(AW), .DESC_W(DW), .DESC_BYTES(DW/8)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .resume(resume),
        .stop_req(stop_req), .desc_base(desc_base), .bus(bus),
        .int_pulse(int_pulse), .adma_err(adma_err), .err_state(err_state),
        .busy(busy), .state(state_o)
    );

    always #5 CLK = ~CLK;

    int total = 0, bad = 0;
    ev_t sbq[$];
    logic [DW-1:0] mem [bit [63:0]];
    bit err_en = 0;
    logic [63:0] err_addr = '0;
    bit mon_en = 0, idle_stop = 0;
    int stop_k = 0, xs_seen = 0;
    logic [63:0] m_ptr = '0;
    bit m_err = 0;
    int m_last = 0;  // 0 end, 1 error, 2 paused by stop_req

    function automatic logic [DW-1:0] mk(input logic [63:0] a, input logic [15:0] len,
                                         input logic [1:0] act, input bit intf,
                                         input bit endf, input bit v);
        return {a, len, 10'd0, act, 1'b0, intf, endf, v};
    endfunction

    task automatic push(input ev_e k, input logic [63:0] a, input logic [16:0] b);
        ev_t e;
        e.kind = k; e.a = a; e.b = b;
        sbq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic sb_check(input ev_e k, input logic [63:0] a, input logic [16:0] b);
        ev_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL sb_%s: got a=%0h b=%0h, expected no event", k.name(), a, b);
            return;
        end
        e = sbq.pop_front();
        if (e.kind != k || e.a !== a || e.b !== b) begin
            bad++;
            $display("FAIL sb_%s: got %s a=%0h b=%0h, expected %s a=%0h b=%0h",
                     k.name(), k.name(), a, b, e.kind.name(), e.a, e.b);
        end
    endtask

    // Reference model: walk the descriptor chain in memory from m_ptr.
    task automatic model_walk(input int k);
        logic [DW-1:0] d;
        logic [1:0] act;
        int ntran = 0;
        for (int i = 0; i < 64; i++) begin
            push(EV_FETCH, m_ptr, 17'd0);
            d = mem.exists(m_ptr) ? mem[m_ptr] : '0;
            if (!d[0] || (err_en && m_ptr == err_addr)) begin
                m_err = 1;
                push(EV_ERR, 64'd1, 17'd0);
                push(EV_STOP, 64'd1, 17'd0);
                m_last = 1;
                return;
            end
            act = d[5:4];
            if (act == 2'b10) begin
                push(EV_XFER, d[95:32], (d[31:16] == 16'd0) ? 17'h10000 : {1'b0, d[31:16]});
                ntran++;
            end
            if (d[2]) push(EV_INT, 64'd0, 17'd0);
            m_ptr = (act == 2'b11) ? d[95:32] : m_ptr + DB;
            if (d[1]) begin
                push(EV_STOP, 64'(m_err), 17'd0); m_last = 0; return;
            end
            if (act == 2'b10 && ntran == k) begin
                push(EV_STOP, 64'(m_err), 17'd0); m_last = 2; return;
            end
        end
    endtask

    task automatic run(input bit is_start, input logic [63:0] base, input int k);
        int c = 0;
        if (is_start) begin m_ptr = base; m_err = 0; end
        model_walk(k);
        stop_k = k; xs_seen = 0;
        @(posedge CLK); #1;
        if (is_start) begin start = 1; desc_base = base; end
        else resume = 1;
        @(posedge CLK); #1;
        start = 0; resume = 0; desc_base = {$urandom, $urandom};
        while (busy && c < 3000) begin @(negedge CLK); c++; end
        total++;
        if (busy) begin bad++; $display("FAIL run_timeout: busy still 1 after %0d cycles", c); end
        repeat (2) @(negedge CLK);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d events missing, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic build_random(output logic [63:0] base);
        logic [63:0] p, q, last_p;
        logic [1:0] act;
        logic [DW-1:0] d;
        int n;
        mem.delete(); err_en = 0;
        n = $urandom_range(1, 6);
        base = {$urandom, 32'h0000_1000};
        p = base; last_p = base;
        for (int i = 0; i < n; i++) begin
            act = 2'($urandom_range(0, 3));
            if (i == n - 1 && act == 2'b11) act = 2'b10;
            if (act == 2'b11) begin
                q = 64'((i + 1) * 65536 + 4 * $urandom_range(0, 255));
                mem[p] = mk(q, 16'd0, act, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
                p = q;
            end else begin
                mem[p] = mk({$urandom, $urandom},
                            ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom),
                            act, 1'($urandom_range(0, 1)), i == n - 1, 1'b1);
                last_p = p;
                p = p + DB;
            end
        end
        case ($urandom_range(0, 7))
            0: begin err_en = 1; err_addr = last_p; end
            1: begin d = mem[last_p]; d[0] = 1'b0; mem[last_p] = d; end
            default: ;
        endcase
    endtask

    // Descriptor-fetch slave with random latency and stray acks outside fetch.
    initial begin
        int fwait = 0;
        logic [63:0] a;
        bus.desc_rd_ack = 0; bus.desc_rd_err = 0; bus.desc_rd_data = '0;
        forever begin
            @(posedge CLK); #1;
            bus.desc_rd_ack = 0; bus.desc_rd_err = 0; bus.desc_rd_data = '0;
            if (bus.desc_rd_req) begin
                if (fwait == 0) begin
                    a = bus.desc_rd_addr;
                    bus.desc_rd_ack  = 1;
                    bus.desc_rd_data = mem.exists(a) ? mem[a] : '0;
                    bus.desc_rd_err  = err_en && (a == err_addr);
                    fwait = $urandom_range(0, 3);
                end else fwait--;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.desc_rd_ack = 1;
            end
        end
    end

    // Data-path slave: completes after at least one full TFR cycle; stray dones elsewhere.
    initial begin
        int tcyc = 0, need = 1;
        bus.xfer_done = 0;
        forever begin
            @(posedge CLK); #1;
            bus.xfer_done = 0;
            if (state_o == 2'd3) begin
                if (tcyc >= need) bus.xfer_done = 1;
                tcyc++;
            end else begin
                tcyc = 0;
                need = $urandom_range(1, 4);
                if ($urandom_range(0, 5) == 0) bus.xfer_done = 1;
            end
        end
    end

    // stop_req driver: first TFR cycle of the k-th transfer, or idle pulses.
    initial begin
        stop_req = 0;
        forever begin
            @(posedge CLK); #1;
            stop_req = 0;
            if (stop_k != 0 && state_o == 2'd3 && xs_seen == stop_k) begin
                stop_req = 1; stop_k = 0;
            end else if (idle_stop && state_o == 2'd0) begin
                stop_req = 1; idle_stop = 0;
            end
            if (bus.xfer_start) xs_seen++;
        end
    end

    // Monitor: turns DUT outputs into events and checks them against the queue.
    initial begin
        bit prev_busy = 0;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (int_pulse) sb_check(EV_INT, 64'd0, 17'd0);
                if (adma_err) sb_check(EV_ERR, 64'(err_state), 17'd0);
                if (prev_busy && !busy) sb_check(EV_STOP, 64'(err_state), 17'd0);
                if (bus.desc_rd_req && bus.desc_rd_ack) sb_check(EV_FETCH, bus.desc_rd_addr, 17'd0);
                if (bus.xfer_start) sb_check(EV_XFER, bus.xfer_addr, bus.xfer_len);
            end
            prev_busy = busy;
        end
    end

    initial begin
        logic [63:0] base;
        bit got;
        RESET = 1; start = 0; resume = 0; desc_base = '0;
        repeat (3) @(negedge CLK);
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req", 64'(bus.desc_rd_req), 64'd0);
        chk("rst_xfer", {46'd0, bus.xfer_start, bus.xfer_len}, 64'd0);
        chk("rst_status", {60'd0, int_pulse, adma_err, err_state}, 64'd0);
        @(posedge CLK); #1;
        RESET = 0;
        mon_en = 1;

        // single TRAN END INT
        mem.delete();
        mem[64'h1000] = mk(64'h8000_0000, 16'h0200, 2'b10, 1, 1, 1);
        run(1, 64'h1000, 0);

        // NOP -> LINK -> TRAN END
        mem.delete();
        mem[64'h1000] = mk(64'h0, 16'h0, 2'b00, 0, 0, 1);
        mem[64'h100C] = mk(64'h4000, 16'h0, 2'b11, 0, 0, 1);
        mem[64'h4000] = mk(64'h9000, 16'h0040, 2'b10, 0, 1, 1);
        run(1, 64'h1000, 0);

        // invalid descriptor, then resume re-fetches the same address
        mem.delete();
        run(1, 64'h2000, 0);
        mem[64'h2000] = mk(64'hA000, 16'h0010, 2'b10, 1, 1, 1);
        run(0, 64'h0, 0);

        // stop_req during the first transfer, idle stop ignored, resume finishes
        mem.delete();
        mem[64'h3000] = mk(64'hB000, 16'h0100, 2'b10, 0, 0, 1);
        mem[64'h300C] = mk(64'hC000, 16'h0200, 2'b10, 1, 0, 1);
        mem[64'h3018] = mk(64'hD000, 16'h0300, 2'b10, 0, 1, 1);
        run(1, 64'h3000, 1);
        idle_stop = 1;
        repeat (3) @(posedge CLK);
        run(0, 64'h0, 0);

        // length 0 -> 65536, pointer advances by 12
        mem.delete();
        mem[64'h5000] = mk(64'h1_2345_0000, 16'h0, 2'b10, 0, 0, 1);
        mem[64'h500C] = mk(64'h0, 16'h0, 2'b00, 1, 1, 1);
        run(1, 64'h5000, 0);

        for (int t = 0; t < 30; t++) begin
            build_random(base);
            run(1, base, $urandom_range(0, 2));
            if (m_last == 2) run(0, 64'h0, 0);
        end
        err_en = 0;

        // asynchronous reset in the middle of a transfer
        mem.delete();
        mem[64'h6000] = mk(64'hE000, 16'h0010, 2'b10, 1, 1, 1);
        mon_en = 0;
        @(posedge CLK); #1;
        start = 1; desc_base = 64'h6000;
        @(posedge CLK); #1;
        start = 0;
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge CLK);
            if (state_o == 2'd3) got = 1;
        end
        chk("tfr_reached", 64'(got), 64'd1);
        #2 RESET = 1;
        #1;
        chk("arst_state", {62'd0, state_o}, 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_xfer", {46'd0, bus.xfer_start, bus.xfer_len}, 64'd0);
        chk("arst_xaddr", bus.xfer_addr, 64'd0);
        chk("arst_req", {63'd0, bus.desc_rd_req}, 64'd0);
        @(posedge CLK); #1;
        RESET = 0;
        sbq.delete(); stop_k = 0;
        m_ptr = 64'd0; m_err = 0;
        @(negedge CLK);
        mon_en = 1;
        mem[64'h0] = mk(64'h0, 16'h0, 2'b00, 1, 1, 1);
        run(0, 64'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
